// File: rtl/saxil_read_regfile.sv
// saxil_read_regfile
//   AXI4-Lite slave read channel in front of a synchronous register file.
//   AR requests are decoded and range-checked, a one-cycle-latency register
//   read is issued, and the responses are queued in an R-channel FIFO.
//   Several reads may be outstanding. RREADY back-pressure never loses data.
//
//   Pipeline: accept (reg_rd_en) -> S1 (reg_rd_data valid) -> FIFO -> R.
//
//   Optional feature: define SAXIL_READ_PROT_CHECK_EN to reject unprivileged
//   reads (arprot[0] == 0) with SLVERR. Otherwise arprot is ignored.
//
// Ports
//   saxil_read_regfile_clk  clock, rising edge
//   saxil_read_regfile_rst  asynchronous active-high reset
//   saxil_read_ar*          AR channel (arready is registered)
//   saxil_read_r*           R channel (served from the FIFO head)
//   reg_rd_en/addr/data     register-file read port, data one cycle after en
module saxil_read_regfile #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        saxil_read_regfile_clk,
  input  logic                        saxil_read_regfile_rst,
  input  logic                        saxil_read_arvalid,
  output logic                        saxil_read_arready,
  input  logic [ADDR_W-1:0]           saxil_read_araddr,
  input  logic [2:0]                  saxil_read_arprot,
  output logic                        saxil_read_rvalid,
  input  logic                        saxil_read_rready,
  output logic [DATA_W-1:0]           saxil_read_rdata,
  output logic [1:0]                  saxil_read_rresp,
  output logic                        reg_rd_en,
  output logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0]           reg_rd_data
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int LSB   = $clog2(DATA_W/8);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } rsp_t;

  // ---------------------------------------------------------------- decode
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             req_err;

  assign accept = saxil_read_arvalid && saxil_read_arready;
  assign idx    = saxil_read_araddr[IDX_W+LSB-1:LSB];

  generate
    if (ADDR_W > IDX_W + LSB) begin : g_range
      assign in_range = (saxil_read_araddr[ADDR_W-1:IDX_W+LSB] == '0);
    end else begin : g_no_range
      assign in_range = 1'b1;
    end
  endgenerate

  // Byte-lane bits never select anything.
  logic unused_lsb;
  assign unused_lsb = ^saxil_read_araddr[LSB-1:0];

`ifdef SAXIL_READ_PROT_CHECK_EN
  // Unprivileged accesses are refused exactly like out-of-range ones.
  assign req_err = !in_range || !saxil_read_arprot[0];
  logic unused_prot;
  assign unused_prot = ^saxil_read_arprot[2:1];
`else
  assign req_err = !in_range;
  logic unused_prot;
  assign unused_prot = ^saxil_read_arprot;
`endif

  // Strobe only for legal accesses; address parked at 0 when idle.
  assign reg_rd_en   = accept && !req_err;
  assign reg_rd_addr = reg_rd_en ? idx : '0;

  // ------------------------------------------------------------------- S1
  logic s1_valid, s1_err;

  always_ff @(posedge saxil_read_regfile_clk or posedge saxil_read_regfile_rst) begin
    if (saxil_read_regfile_rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_err   <= accept && req_err;
    end
  end

  // ----------------------------------------------------------------- FIFO
  rsp_t            mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            push, pop, empty;
  rsp_t            push_rsp, head;
  logic [CW:0]     occ_next;

  assign push          = s1_valid;
  assign push_rsp.data = s1_err ? '0 : reg_rd_data;
  assign push_rsp.resp = s1_err ? RESP_SLVERR : RESP_OKAY;

  assign empty = (count == '0);
  assign pop   = !empty && saxil_read_rready;
  assign head  = mem[rd_ptr];

  assign count_next = count + CW'(push) - CW'(pop);

  // Credit: every accepted request (now in S1 or about to be) owns a slot,
  // so an S1 push can never find the FIFO full.
  assign occ_next = {1'b0, count_next} + (CW+1)'(accept);

  always_ff @(posedge saxil_read_regfile_clk or posedge saxil_read_regfile_rst) begin
    if (saxil_read_regfile_rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      saxil_read_arready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count              <= count_next;
      saxil_read_arready <= occ_next < (CW+1)'(FIFO_DEPTH);
    end
  end

  // Storage needs no reset: the outputs are masked while empty.
  always_ff @(posedge saxil_read_regfile_clk) begin
    if (push) mem[wr_ptr] <= push_rsp;
  end

  assign saxil_read_rvalid = !empty;
  assign saxil_read_rdata  = empty ? '0 : head.data;
  assign saxil_read_rresp  = empty ? '0 : head.resp;

endmodule
